// File: rtl/pio_button_debounce.sv
// Key conditioner feeding the button PIO input port: normalises polarity,
// synchronises, debounces and emits one-cycle press/release pulses per key.
module pio_button_debounce #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned STABLE_COUNT = 50000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    // Terminal count: acceptance happens on the cycle the counter sits here with diff still set.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic [WIDTH-1:0]                norm_c;
    logic [WIDTH-1:0]                diff_c;
    logic [WIDTH-1:0]                accept_c;

    logic [WIDTH-1:0]                s1_d,      s1_q;
    logic [WIDTH-1:0]                s2_d,      s2_q;
    logic [WIDTH-1:0]                stable_d,  stable_q;
    logic [WIDTH-1:0]                press_d,   press_q;
    logic [WIDTH-1:0]                release_d, release_q;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_d,     cnt_q;

    assign norm_c = ACTIVE_LOW ? ~key_raw : key_raw;

    always_comb begin
        s1_d = norm_c;
        s2_d = s1_q;
    end

    // Per-bit stability counter; any return to the stable level restarts the window.
    always_comb begin
        diff_c    = s2_q ^ stable_q;
        accept_c  = '0;
        stable_d  = stable_q;
        cnt_d     = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (diff_c[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept_c[i] = 1'b1;
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
        press_d   = accept_c & s2_q;
        release_d = accept_c & ~s2_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_pio_button_debounce.sv
// Directed bench for pio_button_debounce with STABLE_COUNT=8, CNT_WIDTH=4, active-low keys.
module tb_pio_button_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int n_checks = 0;
    int n_fail   = 0;

    pio_button_debounce #(
        .WIDTH       (4),
        .CNT_WIDTH   (4),
        .STABLE_COUNT(8),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_raw = 4'hF;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_checks++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_held t=%0d level/press/release=%h required 000", t,
                         {key_level, key_press, key_release});
            end
        end
        reset_n = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            n_checks++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_after t=%0d level/press/release=%h required 000", t,
                         {key_level, key_press, key_release});
            end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] exp_l, exp_p;
        key_raw = 4'hE;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_l = (t >= 10) ? 4'h1 : 4'h0;
            exp_p = (t == 10) ? 4'h1 : 4'h0;
            n_checks++;
            if (key_level !== exp_l) begin
                n_fail++;
                $display("FAIL press_level t=%0d got=%h required=%h", t, key_level, exp_l);
            end
            n_checks++;
            if (key_press !== exp_p) begin
                n_fail++;
                $display("FAIL press_pulse t=%0d got=%h required=%h", t, key_press, exp_p);
            end
            n_checks++;
            if (key_release !== 4'h0) begin
                n_fail++;
                $display("FAIL press_release t=%0d got=%h required=0", t, key_release);
            end
        end
    endtask

    // Bit 1: low 5 cycles, high 2, then low and held; bit 0 stays pressed.
    task automatic test_bounce();
        logic [3:0] exp_l, exp_p;
        for (int t = 1; t <= 20; t++) begin
            if (t == 1) key_raw = 4'hC;
            if (t == 6) key_raw = 4'hE;
            if (t == 8) key_raw = 4'hC;
            tick();
            exp_l = (t >= 17) ? 4'h3 : 4'h1;
            exp_p = (t == 17) ? 4'h2 : 4'h0;
            n_checks++;
            if (key_level !== exp_l) begin
                n_fail++;
                $display("FAIL bounce_level t=%0d got=%h required=%h", t, key_level, exp_l);
            end
            n_checks++;
            if (key_press !== exp_p || key_release !== 4'h0) begin
                n_fail++;
                $display("FAIL bounce_pulse t=%0d press=%h release=%h required press=%h release=0",
                         t, key_press, key_release, exp_p);
            end
        end
    endtask

    task automatic test_release_simultaneous();
        logic [3:0] exp_l, exp_r;
        key_raw = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_l = (t >= 10) ? 4'h0 : 4'h3;
            exp_r = (t == 10) ? 4'h3 : 4'h0;
            n_checks++;
            if (key_level !== exp_l) begin
                n_fail++;
                $display("FAIL release_level t=%0d got=%h required=%h", t, key_level, exp_l);
            end
            n_checks++;
            if (key_release !== exp_r || key_press !== 4'h0) begin
                n_fail++;
                $display("FAIL release_pulse t=%0d release=%h press=%h required release=%h press=0",
                         t, key_release, key_press, exp_r);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [3:0] exp_l, exp_p, exp_r;
        key_raw = 4'hB;
        for (int t = 1; t <= 5; t++) begin
            tick();
            n_checks++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                n_fail++;
                $display("FAIL midrst_pre t=%0d level/press/release=%h required 000", t,
                         {key_level, key_press, key_release});
            end
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_checks++;
        if ({key_level, key_press, key_release} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_edge level/press/release=%h required 000",
                     {key_level, key_press, key_release});
        end
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_l = (t >= 10) ? 4'h4 : 4'h0;
            exp_p = (t == 10) ? 4'h4 : 4'h0;
            n_checks++;
            if (key_level !== exp_l) begin
                n_fail++;
                $display("FAIL midrst_level t=%0d got=%h required=%h", t, key_level, exp_l);
            end
            n_checks++;
            if (key_press !== exp_p) begin
                n_fail++;
                $display("FAIL midrst_pulse t=%0d got=%h required=%h", t, key_press, exp_p);
            end
        end
        key_raw = 4'hF;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_l = (t >= 10) ? 4'h0 : 4'h4;
            exp_r = (t == 10) ? 4'h4 : 4'h0;
            n_checks++;
            if (key_level !== exp_l || key_release !== exp_r) begin
                n_fail++;
                $display("FAIL midrst_release t=%0d level=%h release=%h required level=%h release=%h",
                         t, key_level, key_release, exp_l, exp_r);
            end
        end
    endtask

    // Bit 3 low for 7 cycles (rejected) then for 8 cycles (accepted, then released).
    task automatic test_glitch_edge();
        logic [3:0] exp_l, exp_p, exp_r;
        key_raw = 4'h7;
        for (int t = 1; t <= 16; t++) begin
            if (t == 8) key_raw = 4'hF;
            tick();
            n_checks++;
            if ({key_level, key_press, key_release} !== 12'h000) begin
                n_fail++;
                $display("FAIL glitch7 t=%0d level/press/release=%h required 000", t,
                         {key_level, key_press, key_release});
            end
        end
        key_raw = 4'h7;
        for (int t = 1; t <= 20; t++) begin
            if (t == 9) key_raw = 4'hF;
            tick();
            exp_l = (t >= 10 && t < 18) ? 4'h8 : 4'h0;
            exp_p = (t == 10) ? 4'h8 : 4'h0;
            exp_r = (t == 18) ? 4'h8 : 4'h0;
            n_checks++;
            if (key_level !== exp_l) begin
                n_fail++;
                $display("FAIL glitch8_level t=%0d got=%h required=%h", t, key_level, exp_l);
            end
            n_checks++;
            if (key_press !== exp_p || key_release !== exp_r) begin
                n_fail++;
                $display("FAIL glitch8_pulse t=%0d press=%h release=%h required press=%h release=%h",
                         t, key_press, key_release, exp_p, exp_r);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = 4'hF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_simultaneous();
        test_reset_mid_count();
        test_glitch_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
